ls_ctrl: RTL and testbench

- Load/store stage controller. Sits behind the execute-to-load/store pipeline register and consumes its PC/instr/alures/rs2 outputs.
- Decodes memory instructions and issues one request at a time over a valid/ready memory port.
- Stalls the upstream pipeline registers until the access completes.
- Returns aligned, sign/zero-extended load data to writeback.

---
 rtl/ls_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ls_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ls_ctrl.sv
// Load/store stage controller: decodes memory ops, issues one valid/ready
// request at a time, stalls upstream until the access completes and returns
// lane-aligned, sign/zero-extended load data.
module ls_ctrl #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned INST_LEN = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                valid_i,
    input  logic [INST_LEN-1:0] instr_i,
    input  logic [XLEN-1:0]     alures_i,
    input  logic [XLEN-1:0]     rs2_i,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [7:0]          mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    output logic                ls_stall_o,
    output logic                ld_valid_o,
    output logic [XLEN-1:0]     ld_data_o,
    output logic                misalign_o
);

    localparam int unsigned OFF_W  = 3;
    localparam int unsigned MASK_W = 8;
    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

    state_e              state_q, state_d;
    logic                wen_q, wen_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic [XLEN-1:0]     ld_data_q, ld_data_d;

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                is_load, is_store, mem_op, misal;
    logic [1:0]          dec_size;
    logic [OFF_W-1:0]    dec_off;
    logic [MASK_W-1:0]   dec_base, dec_wmask;
    logic [XLEN-1:0]     dec_addr, dec_wdata;
    logic [XLEN-1:0]     rsp_shifted, rsp_ext;
    logic                req_valid_c, stall_c, misalign_c;
    logic                unused_instr;

    assign opcode       = instr_i[6:0];
    assign funct3       = instr_i[14:12];
    assign unused_instr = ^{instr_i[INST_LEN-1:15], instr_i[11:7]};

    // Instruction decode and store-lane formatting from the live inputs
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        mem_op   = valid_i & (is_load | is_store);
        dec_size = funct3[1:0];
        dec_off  = alures_i[OFF_W-1:0];
        dec_addr = {alures_i[XLEN-1:OFF_W], OFF_W'(0)};
        misal    = 1'b0;
        dec_base = 8'h01;
        case (dec_size)
            2'd0: begin dec_base = 8'h01; misal = 1'b0;               end
            2'd1: begin dec_base = 8'h03; misal = dec_off[0];         end
            2'd2: begin dec_base = 8'h0F; misal = |dec_off[1:0];      end
            default: begin dec_base = 8'hFF; misal = |dec_off;        end
        endcase
        dec_wmask = dec_base << dec_off;
        dec_wdata = rs2_i << {dec_off, 3'b000};
    end

    // Load-data lane extraction and sign/zero extension
    always_comb begin
        rsp_shifted = mem_rsp_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rsp_ext = {{(XLEN-8){rsp_shifted[7]  & ~uns_q}}, rsp_shifted[7:0]};
            2'd1:    rsp_ext = {{(XLEN-16){rsp_shifted[15] & ~uns_q}}, rsp_shifted[15:0]};
            2'd2:    rsp_ext = {{(XLEN-32){rsp_shifted[31] & ~uns_q}}, rsp_shifted[31:0]};
            default: rsp_ext = rsp_shifted;
        endcase
    end

    // State register and captured request payload
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            off_q     <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            off_q     <= off_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Next-state, capture and handshake control
    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        ld_data_d   = ld_data_q;
        req_valid_c = 1'b0;
        stall_c     = 1'b0;
        misalign_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op && misal) begin
                    misalign_c = 1'b1;
                end else if (mem_op) begin
                    req_valid_c = 1'b1;
                    stall_c     = 1'b1;
                    wen_d       = is_store;
                    addr_d      = dec_addr;
                    wdata_d     = dec_wdata;
                    wmask_d     = dec_wmask;
                    off_d       = dec_off;
                    size_d      = dec_size;
                    uns_d       = funct3[2];
                    state_d     = mem_req_ready ? S_WAIT : S_REQ;
                end
            end
            S_REQ: begin
                req_valid_c = 1'b1;
                stall_c     = 1'b1;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                stall_c = 1'b1;
                if (mem_rsp_valid) begin
                    if (!wen_q) ld_data_d = rsp_ext;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request port: live decode in IDLE, captured payload while held in REQ
    always_comb begin
        mem_req_valid = req_valid_c & rstn;
        mem_req_wen   = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        mem_req_wmask = '0;
        if (mem_req_valid) begin
            if (state_q == S_IDLE) begin
                mem_req_wen   = is_store;
                mem_req_addr  = dec_addr;
                mem_req_wdata = dec_wdata;
                mem_req_wmask = dec_wmask;
            end else begin
                mem_req_wen   = wen_q;
                mem_req_addr  = addr_q;
                mem_req_wdata = wdata_q;
                mem_req_wmask = wmask_q;
            end
        end
    end

    assign ls_stall_o = stall_c & rstn;
    assign misalign_o = misalign_c & rstn;
    assign ld_valid_o = (state_q == S_DONE) & ~wen_q;
    assign ld_data_o  = ld_data_q;

endmodule

// File: tb/tb_ls_ctrl.sv
// Randomized bench for ls_ctrl with a transaction-level reference model.
module tb_ls_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        valid_i;
    logic [31:0] instr_i;
    logic [63:0] alures_i, rs2_i;
    logic        mem_req_valid, mem_req_ready, mem_req_wen;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic [7:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_rdata;
    logic        ls_stall_o, ld_valid_o, misalign_o;
    logic [63:0] ld_data_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_hs = 0;
    logic [63:0] last_ld = 64'd0;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0110011;

    always #5 clk = ~clk;

    ls_ctrl #(.XLEN(64), .INST_LEN(32)) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .instr_i(instr_i),
        .alures_i(alures_i), .rs2_i(rs2_i),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .ls_stall_o(ls_stall_o), .ld_valid_o(ld_valid_o),
        .ld_data_o(ld_data_o), .misalign_o(misalign_o)
    );

    // Count accepted request handshakes
    always @(posedge clk) begin
        if (mem_req_valid && mem_req_ready) n_hs <= n_hs + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                               input int nbytes, input bit uns);
        logic [63:0] v, mask;
        v = rdata >> (8 * off);
        if (nbytes < 8) begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            v = v & mask;
            if (!uns && v[8 * nbytes - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        check_eq({tag, "_wen"},       64'(mem_req_wen),   64'd0);
        check_eq({tag, "_addr"},      mem_req_addr,       64'd0);
        check_eq({tag, "_wdata"},     mem_req_wdata,      64'd0);
        check_eq({tag, "_wmask"},     64'(mem_req_wmask), 64'd0);
        check_eq({tag, "_stall"},     64'(ls_stall_o),    64'd0);
        check_eq({tag, "_ld_valid"},  64'(ld_valid_o),    64'd0);
        check_eq({tag, "_ld_data"},   ld_data_o,          64'd0);
        check_eq({tag, "_misalign"},  64'(misalign_o),    64'd0);
    endtask

    // One instruction through the stage, with the bench acting as memory
    task automatic run_txn(input bit v, input logic [6:0] opc, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] rs2,
                           input logic [63:0] rdata, input int rdy_dly, input int rsp_dly);
        bit          is_ld, is_st, memop, mis;
        int          nbytes, off, hs0;
        logic [63:0] exp_ld;
        is_ld  = (opc == OPC_LOAD);
        is_st  = (opc == OPC_STORE);
        memop  = v && (is_ld || is_st);
        nbytes = 1 << f3[1:0];
        off    = int'(addr[2:0]);
        mis    = memop && ((off % nbytes) != 0);

        valid_i       = v;
        instr_i       = ($urandom() & 32'hFFFF_8F80) | (32'(f3) << 12) | 32'(opc);
        alures_i      = addr;
        rs2_i         = rs2;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = rdata;
        hs0           = n_hs;

        if (!memop || mis) begin
            @(negedge clk);
            check_eq("nr_misalign",  64'(misalign_o),    64'(mis));
            check_eq("nr_req_valid", 64'(mem_req_valid), 64'd0);
            check_eq("nr_stall",     64'(ls_stall_o),    64'd0);
            check_eq("nr_ld_valid",  64'(ld_valid_o),    64'd0);
            step();
            valid_i = 1'b0;
            @(negedge clk);
            check_eq("nr_after_misalign", 64'(misalign_o), 64'd0);
            check_eq("nr_no_handshake",   64'(n_hs - hs0), 64'd0);
            step();
            return;
        end

        for (int i = 0; i <= rdy_dly; i++) begin
            mem_req_ready = (i == rdy_dly);
            @(negedge clk);
            check_eq("req_valid", 64'(mem_req_valid), 64'd1);
            check_eq("req_stall", 64'(ls_stall_o),    64'd1);
            check_eq("req_addr",  mem_req_addr,       addr & ~64'd7);
            check_eq("req_wen",   64'(mem_req_wen),   64'(is_st));
            check_eq("req_wmask", 64'(mem_req_wmask), 64'(((1 << nbytes) - 1) << off));
            if (is_st) check_eq("req_wdata", mem_req_wdata, rs2 << (8 * off));
            check_eq("req_misalign", 64'(misalign_o), 64'd0);
            step();
        end
        mem_req_ready = 1'b0;

        for (int j = 0; j <= rsp_dly; j++) begin
            mem_rsp_valid = (j == rsp_dly);
            @(negedge clk);
            check_eq("wait_req_valid", 64'(mem_req_valid), 64'd0);
            check_eq("wait_stall",     64'(ls_stall_o),    64'd1);
            check_eq("wait_ld_valid",  64'(ld_valid_o),    64'd0);
            step();
        end
        mem_rsp_valid = 1'b0;

        @(negedge clk);
        check_eq("done_stall",     64'(ls_stall_o),    64'd0);
        check_eq("done_req_valid", 64'(mem_req_valid), 64'd0);
        check_eq("done_ld_valid",  64'(ld_valid_o),    64'(is_ld));
        if (is_ld) begin
            exp_ld  = model_load(rdata, off, nbytes, f3[2]);
            last_ld = exp_ld;
        end
        check_eq("done_ld_data",   ld_data_o,          last_ld);
        check_eq("one_handshake",  64'(n_hs - hs0),    64'd1);
        step();
        valid_i = 1'b0;

        @(negedge clk);
        check_eq("idle_stall",    64'(ls_stall_o), 64'd0);
        check_eq("idle_ld_valid", 64'(ld_valid_o), 64'd0);
        check_eq("idle_ld_hold",  ld_data_o,       last_ld);
        step();
    endtask

    initial begin
        int          kind, rdy, rsp;
        bit          v;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] a, d, r;

        rstn = 1'b0; valid_i = 1'b0; instr_i = '0; alures_i = '0; rs2_i = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
        #1;
        check_reset_outputs("por");
        step(); step();
        rstn = 1'b1;
        step();

        // Directed cases
        run_txn(1, OPC_LOAD,  3'd3, 64'h8000_0010, 64'd0, 64'h1122_3344_5566_7788, 0, 0);
        run_txn(1, OPC_LOAD,  3'd0, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 0, 0);
        run_txn(1, OPC_LOAD,  3'd4, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1, 2);
        run_txn(1, OPC_STORE, 3'd1, 64'h8000_0006, 64'h0000_0000_0000_ABCD, 64'd0, 0, 0);
        run_txn(1, OPC_STORE, 3'd2, 64'h8000_0004, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 3, 1);
        run_txn(1, OPC_LOAD,  3'd2, 64'h8000_0002, 64'd0, 64'd0, 0, 0);
        run_txn(1, OPC_ALU,   3'd3, 64'h8000_0000, 64'd0, 64'd0, 0, 0);

        // Reset while waiting for the response
        valid_i = 1'b1;
        instr_i = (32'd3 << 12) | 32'(OPC_LOAD);
        alures_i = 64'h8000_0010;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step();
        rstn = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(posedge clk); #1;
        valid_i = 1'b0;
        rstn = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'hFFFF_0000_FFFF_0000;
        @(negedge clk);
        check_eq("post_rst_ld_valid", 64'(ld_valid_o), 64'd0);
        check_eq("post_rst_stall",    64'(ls_stall_o), 64'd0);
        step();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ld_valid2", 64'(ld_valid_o), 64'd0);
        check_eq("post_rst_ld_data",   ld_data_o,       64'd0);
        last_ld = 64'd0;
        step();
        run_txn(1, OPC_LOAD, 3'd3, 64'h8000_0018, 64'd0, 64'h0102_0304_0506_0708, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            v    = 1'b1;
            if (kind == 0)      opc = OPC_ALU;
            else if (kind == 1) begin opc = OPC_LOAD; v = 1'b0; end
            else if (kind < 6)  opc = OPC_LOAD;
            else                opc = OPC_STORE;
            f3 = (opc == OPC_STORE) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            a  = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            d   = {$urandom(), $urandom()};
            r   = {$urandom(), $urandom()};
            rdy = $urandom_range(0, 3);
            rsp = $urandom_range(0, 3);
            run_txn(v, opc, f3, a, d, r, rdy, rsp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
